// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/exec/mem/writeback per instruction.
// Latency: DP 4, LW 5, SW 4, BEQ/BNE/J 3 cycles, plus one per memory wait cycle.
// Backpressure: holds imem_req until imem_rdy and dmem_req until dmem_rdy, with no timeout.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       alu_zero,
    input  logic       imem_rdy,
    input  logic       dmem_rdy,
    output logic       imem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [3:0] OP_LW  = 4'b0000;
    localparam logic [3:0] OP_SW  = 4'b0001;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_BNE = 4'b1100;
    localparam logic [3:0] OP_J   = 4'b1101;

    localparam logic [1:0] PC_PLUS2  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_DP   = 2'b00;
    localparam logic [1:0] ALU_CMP  = 2'b01;
    localparam logic [1:0] ALU_ADDR = 2'b10;

    state_t     cur_state;
    state_t     nxt_state;
    logic [3:0] op_q;

    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_bne;
    logic is_j;
    logic is_mem;
    logic is_br;
    logic is_dp;
    logic br_taken;

    // Everything below decodes from the latched opcode, never the live input.
    assign is_lw    = (op_q == OP_LW);
    assign is_sw    = (op_q == OP_SW);
    assign is_beq   = (op_q == OP_BEQ);
    assign is_bne   = (op_q == OP_BNE);
    assign is_j     = (op_q == OP_J);
    assign is_mem   = is_lw | is_sw;
    assign is_br    = is_beq | is_bne;
    assign is_dp    = ~(is_mem | is_br | is_j);
    assign br_taken = (is_beq & alu_zero) | (is_bne & ~alu_zero);

    assign state = cur_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_IDLE;
            op_q      <= 4'b0000;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE:   nxt_state = S_FETCH;
            S_FETCH:  if (imem_rdy) nxt_state = S_DECODE;
            S_DECODE: nxt_state = S_EXEC;
            S_EXEC: begin
                if (is_mem)     nxt_state = S_MEM;
                else if (is_dp) nxt_state = S_WB;
                else            nxt_state = S_FETCH;
            end
            S_MEM: begin
                if (dmem_rdy) nxt_state = is_lw ? S_WB : S_FETCH;
            end
            S_WB:     nxt_state = S_FETCH;
            default:  nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS2;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = ALU_DP;
        instr_done = 1'b0;
        case (cur_state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_rdy;
            end
            S_EXEC: begin
                if (is_mem) begin
                    alu_op  = ALU_ADDR;
                    alu_src = 1'b1;
                end else if (is_br) begin
                    alu_op     = ALU_CMP;
                    pc_write   = 1'b1;
                    pc_src     = br_taken ? PC_BRANCH : PC_PLUS2;
                    instr_done = 1'b1;
                end else if (is_j) begin
                    pc_write   = 1'b1;
                    pc_src     = PC_JUMP;
                    instr_done = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                alu_op   = ALU_ADDR;
                alu_src  = 1'b1;
                // A store retires here; a load still needs its writeback cycle.
                if (dmem_rdy && is_sw) begin
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_lw;
                reg_dst    = is_dp;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and output vector checks.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic       alu_zero;
    logic       imem_rdy;
    logic       dmem_rdy;
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       instr_done;
    logic [2:0] state;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
        .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .imem_req(imem_req),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .alu_op(alu_op), .instr_done(instr_done), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit order: imem_req ir_write pc_write pc_src[2] dmem_req dmem_we
    //            reg_write reg_dst alu_src mem_to_reg alu_op[2] instr_done
    localparam logic [13:0] O_ZERO    = 14'b0_0_0_00_0_0_0_0_0_0_00_0;
    localparam logic [13:0] O_F_WAIT  = 14'b1_0_0_00_0_0_0_0_0_0_00_0;
    localparam logic [13:0] O_F_RDY   = 14'b1_1_0_00_0_0_0_0_0_0_00_0;
    localparam logic [13:0] O_E_LS    = 14'b0_0_0_00_0_0_0_0_1_0_10_0;
    localparam logic [13:0] O_E_BR_T  = 14'b0_0_1_01_0_0_0_0_0_0_01_1;
    localparam logic [13:0] O_E_BR_N  = 14'b0_0_1_00_0_0_0_0_0_0_01_1;
    localparam logic [13:0] O_E_J     = 14'b0_0_1_10_0_0_0_0_0_0_00_1;
    localparam logic [13:0] O_M_LW    = 14'b0_0_0_00_1_0_0_0_1_0_10_0;
    localparam logic [13:0] O_M_SW_W  = 14'b0_0_0_00_1_1_0_0_1_0_10_0;
    localparam logic [13:0] O_M_SW_R  = 14'b0_0_1_00_1_1_0_0_1_0_10_1;
    localparam logic [13:0] O_WB_DP   = 14'b0_0_1_00_0_0_1_1_0_0_00_1;
    localparam logic [13:0] O_WB_LW   = 14'b0_0_1_00_0_0_1_0_0_1_00_1;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                           S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5;

    function automatic logic [13:0] outs();
        return {imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we,
                reg_write, reg_dst, alu_src, mem_to_reg, alu_op, instr_done};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Checks state and outputs mid-cycle, then advances past the next rising edge.
    task automatic cyc(input string tag, input logic [2:0] es, input logic [13:0] eo);
        @(negedge clk);
        chk({tag, " state"}, {13'b0, state}, {13'b0, es});
        chk({tag, " outs"}, {2'b0, outs()}, {2'b0, eo});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = 4'b0000; alu_zero = 1'b0; imem_rdy = 1'b0; dmem_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", {13'b0, state}, {13'b0, S_IDLE});
        chk("reset outs", {2'b0, outs()}, {2'b0, O_ZERO});
        rst_n = 1'b1;
        cyc("post-reset idle", S_IDLE, O_ZERO);

        // DP 0010 with zero-wait fetch: 1,2,3,5
        imem_rdy = 1'b1; opcode = 4'b0010;
        cyc("dp fetch", S_FETCH, O_F_RDY);
        cyc("dp decode", S_DECODE, O_ZERO);
        cyc("dp exec", S_EXEC, O_ZERO);
        cyc("dp wb", S_WB, O_WB_DP);

        // LW with two dmem wait cycles; early dmem_rdy in EXEC must be ignored
        opcode = 4'b0000;
        cyc("lw fetch", S_FETCH, O_F_RDY);
        cyc("lw decode", S_DECODE, O_ZERO);
        dmem_rdy = 1'b1;
        cyc("lw exec", S_EXEC, O_E_LS);
        dmem_rdy = 1'b0;
        cyc("lw mem w1", S_MEM, O_M_LW);
        cyc("lw mem w2", S_MEM, O_M_LW);
        dmem_rdy = 1'b1;
        cyc("lw mem rdy", S_MEM, O_M_LW);
        dmem_rdy = 1'b0;
        cyc("lw wb", S_WB, O_WB_LW);

        // BEQ taken, then BNE not taken, both with alu_zero = 1
        opcode = 4'b1011; alu_zero = 1'b1;
        cyc("beq fetch", S_FETCH, O_F_RDY);
        cyc("beq decode", S_DECODE, O_ZERO);
        cyc("beq exec", S_EXEC, O_E_BR_T);
        opcode = 4'b1100;
        cyc("bne fetch", S_FETCH, O_F_RDY);
        cyc("bne decode", S_DECODE, O_ZERO);
        cyc("bne exec", S_EXEC, O_E_BR_N);
        alu_zero = 1'b0;

        // J
        opcode = 4'b1101;
        cyc("j fetch", S_FETCH, O_F_RDY);
        cyc("j decode", S_DECODE, O_ZERO);
        cyc("j exec", S_EXEC, O_E_J);

        // Opcode toggling outside DECODE: the SW latched in DECODE wins
        imem_rdy = 1'b0;
        cyc("tog fetch wait", S_FETCH, O_F_WAIT);
        imem_rdy = 1'b1; opcode = 4'b1101;
        cyc("tog fetch rdy", S_FETCH, O_F_RDY);
        opcode = 4'b0001;
        cyc("tog decode", S_DECODE, O_ZERO);
        opcode = 4'b1101;
        cyc("tog exec", S_EXEC, O_E_LS);
        opcode = 4'b0010; dmem_rdy = 1'b1;
        cyc("tog mem rdy", S_MEM, O_M_SW_R);
        dmem_rdy = 1'b0;

        // DP SET 1010 closes on a WB with reg_dst
        opcode = 4'b1010;
        cyc("set fetch", S_FETCH, O_F_RDY);
        cyc("set decode", S_DECODE, O_ZERO);
        cyc("set exec", S_EXEC, O_ZERO);
        cyc("set wb", S_WB, O_WB_DP);

        // SW aborted by reset while dmem_req is high
        opcode = 4'b0001;
        cyc("abort fetch", S_FETCH, O_F_RDY);
        cyc("abort decode", S_DECODE, O_ZERO);
        cyc("abort exec", S_EXEC, O_E_LS);
        imem_rdy = 1'b0;
        @(negedge clk);
        chk("abort mem state", {13'b0, state}, {13'b0, S_MEM});
        chk("abort mem outs", {2'b0, outs()}, {2'b0, O_M_SW_W});
        #2;
        rst_n = 1'b0;
        dmem_rdy = 1'b1;
        #1;
        chk("async reset state", {13'b0, state}, {13'b0, S_IDLE});
        chk("async reset outs", {2'b0, outs()}, {2'b0, O_ZERO});
        @(posedge clk);
        #1;
        chk("held reset outs", {2'b0, outs()}, {2'b0, O_ZERO});
        rst_n = 1'b1; dmem_rdy = 1'b0;
        cyc("release idle", S_IDLE, O_ZERO);
        cyc("release fetch", S_FETCH, O_F_WAIT);
        cyc("fetch still waiting", S_FETCH, O_F_WAIT);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  4  instruction opcode from the instruction register; sampled only in DECODE.
REQ-005 alu_zero  input  1  ALU zero flag; valid in EXEC.
REQ-006 imem_rdy  input  1  instruction memory has data valid for the current imem_req.
REQ-007 dmem_rdy  input  1  data memory has completed the current dmem_req.
REQ-008 imem_req  output  1  instruction fetch request.
REQ-009 ir_write  output  1  load the instruction register.
REQ-010 pc_write  output  1  update the PC.
REQ-011 pc_src  output  2  PC select: 00 = PC+2, 01 = branch target, 10 = jump target.
REQ-012 dmem_req / dmem_we  output  1 each  data memory request; write enable.
REQ-013 reg_write, reg_dst, alu_src, mem_to_reg  output  1 each  datapath controls with the same meanings as the single-cycle decoder.
REQ-014 alu_op  output  2  00 = data processing, 01 = compare/subtract, 10 = address add.
REQ-015 instr_done  output  1  one-cycle pulse on the last cycle of each instruction.
REQ-016 state  output  3  current state code, for debug.

Function
REQ-017 SHALL implement the following states and codes: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5.
REQ-018 IDLE: all outputs 0; SHALL move to FETCH on the next clock edge.
REQ-019 FETCH: imem_req = 1, held until imem_rdy.
  - While imem_rdy = 1: ir_write = 1 in that cycle (Mealy).
  - Next state: DECODE.
REQ-020 DECODE: SHALL latch opcode into an internal register (op_q); next state EXEC; no datapath outputs asserted.
REQ-021 Opcode classes, decoded from op_q:
  - 0000 = LW; 0001 = SW.
  - 0010-1001, 1010 (SET), 1110, 1111 = data processing (DP).
  - 1011 = BEQ; 1100 = BNE; 1101 = J.
REQ-022 EXEC, DP: alu_op = 00, alu_src = 0; next state WB.
REQ-023 EXEC, LW/SW: alu_op = 10, alu_src = 1; next state MEM.
REQ-024 EXEC, BEQ/BNE: alu_op = 01, alu_src = 0, pc_write = 1, instr_done = 1; next state FETCH.
  - pc_src = 01 if (BEQ and alu_zero) or (BNE and !alu_zero); otherwise 00.
REQ-025 EXEC, J: pc_write = 1, pc_src = 10, instr_done = 1; next state FETCH.
REQ-026 MEM: dmem_req = 1, dmem_we = 1 for SW only, alu_op = 10, alu_src = 1; all held until dmem_rdy.
REQ-027 MEM exit with dmem_rdy = 1:
  - SW: pc_write = 1, pc_src = 00, instr_done = 1; next state FETCH.
  - LW: next state WB.
REQ-028 WB: reg_write = 1, mem_to_reg = (op_q == LW), reg_dst = (class DP), pc_write = 1, pc_src = 00, instr_done = 1; next state FETCH.
REQ-029 Any output not listed for a state SHALL be 0.
REQ-030 Requests SHALL NOT be withdrawn before the ready handshake; wait time is unbounded, with no timeout.
REQ-031 imem_rdy outside FETCH and dmem_rdy outside MEM SHALL be ignored.
REQ-032 Opcode changes outside DECODE SHALL NOT affect behaviour.
REQ-033 Latency with zero-wait memories:
  - DP = 4 cycles (FETCH, DECODE, EXEC, WB).
  - LW = 5; SW = 4; BEQ/BNE/J = 3.
  - Each memory wait cycle adds 1.
REQ-034 pc_write SHALL be asserted exactly once per instruction.

Reset
REQ-035 rst_n low SHALL immediately (asynchronously) force state = IDLE, op_q = 0000, and all outputs to 0.
REQ-036 Reset asserted mid-instruction (including MEM with dmem_req high) SHALL abort it with no pc_write, reg_write or instr_done.
REQ-037 After rst_n rises, the first imem_req SHALL appear on the second rising edge.

Verification
REQ-038 DP opcode 0010, imem_rdy = 1 in FETCH -> state sequence 1,2,3,5; reg_write = 1 and reg_dst = 1 only in WB; instr_done pulses on cycle 4.
REQ-039 LW, dmem_rdy delayed 2 cycles -> dmem_req high 3 cycles with dmem_we = 0; WB has mem_to_reg = 1; total 7 cycles.
REQ-040 BEQ with alu_zero = 1 -> pc_src = 01; BNE with alu_zero = 1 -> pc_src = 00; each takes 3 cycles with one pc_write.
REQ-041 J (1101) -> pc_src = 10 in EXEC; reg_write never asserted.
REQ-042 SW with rst_n pulsed low during MEM -> outputs 0 immediately; IDLE; then imem_req on the 2nd edge after release.
REQ-043 opcode toggled during FETCH wait and during EXEC -> behaviour follows the value latched in DECODE.
